// File: rtl/uart_alu_ctrl_pkg.sv
// Shared types and constants for the UART-to-ALU frame sequencer.
package uart_alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 6;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    // ALU opcodes (MIPS funct-style encodings)
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// UART FIFO handshake plus ALU operand/result bus seen by the sequencer.
interface uart_alu_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) ();
    logic              rx_empty;
    logic [DATA_W-1:0] r_data;
    logic              rd_uart;
    logic              tx_full;
    logic              wr_uart;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;

    modport master (
        input  rx_empty, r_data, tx_full, alu_result,
        output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op
    );

    modport slave (
        output rx_empty, r_data, tx_full, alu_result,
        input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/uart_alu_ctrl_timeout_cnt.sv
// Inter-byte timer: counts idle cycles, flags the last allowed one.
module uart_timeout_cnt #(
    parameter int unsigned TIMEOUT = 50000000,
    parameter int          CNT_W   = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    // TIMEOUT=0 disables the timer; the terminal value is then unused.
    localparam logic [CNT_W-1:0] TC_VAL = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority, disabled timer stays at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (TIMEOUT == 0 || clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (TIMEOUT != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: pops A, B, opcode from the rx FIFO, runs the external
// combinational ALU and pushes the registered result into the tx FIFO.
//
//   state  | meaning
//   GET_A  | idle, waiting for operand A
//   GET_B  | waiting for operand B (inter-byte timer running)
//   GET_OP | waiting for opcode byte (inter-byte timer running)
//   EXEC   | capture ALU result
//   SEND   | push result, stall while tx FIFO is full
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int          DATA_W  = DATA_W_DEF,
    parameter int          OP_W    = OP_W_DEF,
    parameter int unsigned TIMEOUT = 50000000,
    parameter int          CNT_W   = 26
) (
    input  logic            clk,
    input  logic            reset,
    uart_alu_ctrl_if.master bus,
    output logic            busy,
    output logic            timeout
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic rd_c, wr_c, timeout_c;
    logic cnt_clr, cnt_en, cnt_tc;

    uart_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // Next-state, datapath capture and handshake strobes.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        result_d  = result_q;
        rd_c      = 1'b0;
        wr_c      = 1'b0;
        timeout_c = 1'b0;
        cnt_clr   = 1'b1;
        cnt_en    = 1'b0;
        case (state_q)
            GET_A: begin
                if (!bus.rx_empty) begin
                    rd_c    = 1'b1;
                    alu_a_d = bus.r_data;
                    state_d = GET_B;
                end
            end
            GET_B, GET_OP: begin
                // A byte arriving on the terminal cycle wins over the timeout.
                if (!bus.rx_empty) begin
                    rd_c = 1'b1;
                    if (state_q == GET_B) begin
                        alu_b_d = bus.r_data;
                        state_d = GET_OP;
                    end else begin
                        alu_op_d = bus.r_data[OP_W-1:0];
                        state_d  = EXEC;
                    end
                end else if (cnt_tc) begin
                    timeout_c = 1'b1;
                    state_d   = GET_A;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
            end
            EXEC: begin
                result_d = bus.alu_result;
                state_d  = SEND;
            end
            SEND: begin
                if (!bus.tx_full) begin
                    wr_c    = 1'b1;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= GET_A;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
        end
    end

    // Strobes are gated by reset so a waiting rx byte cannot pop during reset.
    assign bus.rd_uart = rd_c & ~reset;
    assign bus.wr_uart = wr_c & ~reset;
    assign bus.w_data  = result_q;
    assign bus.alu_a   = alu_a_q;
    assign bus.alu_b   = alu_b_q;
    assign bus.alu_op  = alu_op_q;
    assign busy        = (state_q != GET_A) & ~reset;
    assign timeout     = timeout_c & ~reset;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: queue-based rx FIFO, behavioural ALU and a
// frame-level reference model compared against the DUT every cycle.
module tb_uart_alu_ctrl;
    import uart_alu_pkg::*;

    localparam int TO = 20;

    logic clk = 1'b0;
    logic reset;
    logic busy, timeout;

    uart_alu_ctrl_if #(.DATA_W(8), .OP_W(6)) bus ();

    uart_alu_ctrl #(
        .DATA_W  (8),
        .OP_W    (6),
        .TIMEOUT (TO),
        .CNT_W   (26)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SRA:  return 8'($signed(a) >>> b[2:0]);
            OP_SRL:  return a >> b[2:0];
            OP_NOR:  return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

    logic [7:0] rxq[$];

    // reference model: bytes gathered in current frame, frame phase
    // (0 gathering, 1 computing, 2 delivering), idle wait cycles
    int         m_got, m_phase, m_wait;
    logic [7:0] m_a, m_b, m_res;
    logic [5:0] m_op;

    int         n_chk = 0, n_pass = 0;
    int         n_wr = 0, n_to = 0;
    logic [7:0] last_w = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    task automatic refresh();
        bus.rx_empty = (rxq.size() == 0);
        bus.r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        refresh();
    endtask

    task automatic model_clear();
        m_got = 0; m_phase = 0; m_wait = 0;
        m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_res = 8'h00;
    endtask

    task automatic step();
        logic has, e_rd, e_wr, e_to, e_busy, s_rd;
        logic [7:0] head;
        @(negedge clk);
        has    = (rxq.size() > 0);
        head   = has ? rxq[0] : 8'h00;
        e_busy = !(m_phase == 0 && m_got == 0);
        e_rd   = (m_phase == 0) && has;
        e_to   = (m_phase == 0) && (m_got > 0) && !has && (TO != 0) && (m_wait + 1 == TO);
        e_wr   = (m_phase == 2) && !bus.tx_full;
        chk("rd_uart", 32'(bus.rd_uart), 32'(e_rd));
        chk("wr_uart", 32'(bus.wr_uart), 32'(e_wr));
        chk("timeout", 32'(timeout), 32'(e_to));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("alu_a", 32'(bus.alu_a), 32'(m_a));
        chk("alu_b", 32'(bus.alu_b), 32'(m_b));
        chk("alu_op", 32'(bus.alu_op), 32'(m_op));
        if (m_phase == 2) chk("w_data", 32'(bus.w_data), 32'(m_res));
        s_rd = bus.rd_uart;
        if (bus.wr_uart) begin
            n_wr++;
            last_w = bus.w_data;
        end
        if (timeout) n_to++;
        @(posedge clk);
        case (m_phase)
            0: begin
                if (e_rd) begin
                    if (m_got == 0) m_a = head;
                    else if (m_got == 1) m_b = head;
                    else m_op = head[5:0];
                    m_got++;
                    m_wait = 0;
                    if (m_got == 3) m_phase = 1;
                end else if (e_to) begin
                    m_got  = 0;
                    m_wait = 0;
                end else if (m_got > 0) begin
                    m_wait++;
                end
            end
            1: begin
                m_res   = alu_fn(m_a, m_b, m_op);
                m_phase = 2;
            end
            default: begin
                if (e_wr) begin
                    m_phase = 0;
                    m_got   = 0;
                end
            end
        endcase
        if (s_rd && rxq.size() > 0) void'(rxq.pop_front());
        #1;
        refresh();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int w0, t0;
        logic [7:0] ra, rb, rop;
        reset       = 1'b1;
        bus.tx_full = 1'b0;
        refresh();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", 32'(bus.rd_uart), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_a", 32'(bus.alu_a), 0);
        chk("rst_w_data", 32'(bus.w_data), 0);
        reset = 1'b0;

        // back-to-back ADD frame
        w0 = n_wr;
        push(8'h05); push(8'h03); push(8'h20);
        run(8);
        chk("add_wr_cnt", 32'(n_wr - w0), 1);
        chk("add_w_data", 32'(last_w), 32'h08);

        // spaced OR frame, gaps below the timeout
        w0 = n_wr; t0 = n_to;
        push(8'hF0); run(TO - 5);
        push(8'h0F); run(TO - 5);
        push(8'h25); run(6);
        chk("or_wr_cnt", 32'(n_wr - w0), 1);
        chk("or_to_cnt", 32'(n_to - t0), 0);
        chk("or_w_data", 32'(last_w), 32'hFF);

        // partial frame abandoned, then a SUB frame
        w0 = n_wr; t0 = n_to;
        push(8'h11); run(TO + 5);
        chk("to_cnt", 32'(n_to - t0), 1);
        chk("to_no_wr", 32'(n_wr - w0), 0);
        push(8'h02); push(8'h01); push(8'h22);
        run(6);
        chk("sub_w_data", 32'(last_w), 32'h01);

        // byte arriving on the terminal cycle wins
        w0 = n_wr; t0 = n_to;
        push(8'h07); run(1); run(TO - 1);
        push(8'h09); run(1);
        push(8'h20); run(6);
        chk("tc_race_to", 32'(n_to - t0), 0);
        chk("tc_race_w", 32'(last_w), 32'h10);
        chk("tc_race_wr", 32'(n_wr - w0), 1);

        // tx FIFO full stall with the next frame queued
        w0 = n_wr;
        bus.tx_full = 1'b1;
        push(8'h21); push(8'h12); push(8'h26);
        run(4);
        push(8'h40); push(8'h02); push(8'h20);
        run(50);
        chk("stall_no_wr", 32'(n_wr - w0), 0);
        bus.tx_full = 1'b0;
        run(10);
        chk("stall_wr_cnt", 32'(n_wr - w0), 2);
        chk("stall_w_data", 32'(last_w), 32'h42);

        // reset while waiting for the opcode
        w0 = n_wr;
        push(8'hAA); push(8'h55);
        run(3);
        reset = 1'b1;
        #1;
        chk("mid_rst_rd", 32'(bus.rd_uart), 0);
        chk("mid_rst_wr", 32'(bus.wr_uart), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_a", 32'(bus.alu_a), 0);
        chk("mid_rst_b", 32'(bus.alu_b), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        push(8'h10); push(8'h20); push(8'h20);
        run(6);
        chk("post_rst_wr", 32'(n_wr - w0), 1);
        chk("post_rst_w", 32'(last_w), 32'h30);

        // opcode upper bits dropped
        push(8'h3C); push(8'h5A); push(8'hE6);
        run(6);
        chk("op_trunc", 32'(bus.alu_op), 32'h26);
        chk("xor_w_data", 32'(last_w), 32'h66);

        // randomized traffic with idle windows long enough to time out
        for (int i = 0; i < 900; i++) begin
            if ((i % 150) < 100 && $urandom_range(0, 2) == 0) begin
                ra = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    rop = 8'($urandom_range(0, 7));
                    case (rop[2:0])
                        3'd0: rb = {2'b00, OP_ADD};
                        3'd1: rb = {2'b01, OP_SUB};
                        3'd2: rb = {2'b10, OP_AND};
                        3'd3: rb = {2'b11, OP_OR};
                        3'd4: rb = {2'b00, OP_XOR};
                        3'd5: rb = {2'b01, OP_SRA};
                        3'd6: rb = {2'b10, OP_SRL};
                        default: rb = {2'b11, OP_NOR};
                    endcase
                    ra = rb;
                end
                push(ra);
            end
            bus.tx_full = ($urandom_range(0, 3) == 0);
            step();
        end
        bus.tx_full = 1'b0;
        run(3 * TO);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
